// File: rtl/ps2_cmd_sequencer.sv
// PS/2 keyboard command sequencer: reset and LED commands with ack, resend and timeout.
// Define PS2_CMD_TYPEMATIC_EN to add the typematic-rate command (0xF3) at lowest priority.
module ps2_cmd_sequencer #(
  parameter int TIMEOUT   = 1000000,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reset_req,
  input  logic       led_req,
  input  logic [2:0] led_val,
`ifdef PS2_CMD_TYPEMATIC_EN
  input  logic       typematic_req,
  input  logic [6:0] typematic_val,
`endif
  output logic [7:0] tx_data,
  output logic       tx_write,
  input  logic       tx_write_ack,
  input  logic       tx_no_ack,
  input  logic [7:0] rx_scan_code,
  input  logic       rx_data_ready,
  output logic       rx_read,
  output logic       rx_claim,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_WACK, WAIT_RESP, WAIT_BAT, FINISH
  } state_t;

  typedef enum logic [1:0] {
    CMD_RST, CMD_LED, CMD_TYP
  } cmd_t;

  state_t          r_state;
  cmd_t            r_cmd;
  logic            r_idx;
  logic [RW-1:0]   r_retry;
  logic [TW-1:0]   r_timer;
  logic [7:0]      r_arg;
  logic [7:0]      r_tx_data;
  logic [2:0]      r_led_val;
  logic            r_pend_rst;
  logic            r_pend_led;
  logic            r_tx_write;
  logic            r_rx_read;
  logic            r_rx_seen;
  logic            r_done;
  logic [1:0]      r_err;

  logic            w_go_rst;
  logic            w_go_led;
  logic            w_fire;
  logic [2:0]      w_led_arg;
  logic [7:0]      w_byte;

`ifdef PS2_CMD_TYPEMATIC_EN
  logic            r_pend_typ;
  logic [6:0]      r_typ_val;
  logic            w_go_typ;
  logic [6:0]      w_typ_arg;

  assign w_go_typ  = typematic_req | r_pend_typ;
  assign w_typ_arg = typematic_req ? typematic_val : r_typ_val;
`endif

  assign w_go_rst  = reset_req | r_pend_rst;
  assign w_go_led  = led_req | r_pend_led;
  assign w_led_arg = led_req ? led_val : r_led_val;
  // one read per rx_data_ready assertion
  assign w_fire    = rx_data_ready & ~r_rx_seen;

  assign tx_data   = r_tx_data;
  assign tx_write  = r_tx_write;
  assign rx_read   = r_rx_read;
  assign busy      = (r_state != IDLE);
  assign rx_claim  = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;

  always_comb begin
    w_byte = 8'hFF;
    if (r_idx) begin
      w_byte = r_arg;
    end else begin
      case (r_cmd)
        CMD_LED: w_byte = 8'hED;
        CMD_TYP: w_byte = 8'hF3;
        default: w_byte = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cmd      <= CMD_RST;
      r_idx      <= 1'b0;
      r_retry    <= '0;
      r_timer    <= '0;
      r_arg      <= 8'h00;
      r_tx_data  <= 8'h00;
      r_led_val  <= 3'b000;
      r_pend_rst <= 1'b0;
      r_pend_led <= 1'b0;
      r_tx_write <= 1'b0;
      r_rx_read  <= 1'b0;
      r_rx_seen  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 2'd0;
`ifdef PS2_CMD_TYPEMATIC_EN
      r_pend_typ <= 1'b0;
      r_typ_val  <= 7'd0;
`endif
    end else begin
      r_tx_write <= 1'b0;
      r_rx_read  <= 1'b0;
      r_done     <= 1'b0;
      if (led_req) r_led_val <= led_val;
`ifdef PS2_CMD_TYPEMATIC_EN
      if (typematic_req) r_typ_val <= typematic_val;
`endif
      if (!rx_data_ready) r_rx_seen <= 1'b0;

      case (r_state)
        IDLE: begin
          r_idx   <= 1'b0;
          r_retry <= '0;
          if (w_go_rst) begin
            r_cmd      <= CMD_RST;
            r_state    <= SEND;
            r_pend_rst <= 1'b0;
            r_pend_led <= w_go_led;
`ifdef PS2_CMD_TYPEMATIC_EN
            r_pend_typ <= w_go_typ;
`endif
          end else if (w_go_led) begin
            r_cmd      <= CMD_LED;
            r_arg      <= {5'b0, w_led_arg};
            r_state    <= SEND;
            r_pend_led <= 1'b0;
`ifdef PS2_CMD_TYPEMATIC_EN
            r_pend_typ <= w_go_typ;
`endif
          end
`ifdef PS2_CMD_TYPEMATIC_EN
          else if (w_go_typ) begin
            r_cmd      <= CMD_TYP;
            r_arg      <= {1'b0, w_typ_arg};
            r_state    <= SEND;
            r_pend_typ <= 1'b0;
          end
`endif
        end
        SEND: begin
          r_tx_data  <= w_byte;
          r_tx_write <= 1'b1;
          r_state    <= WAIT_WACK;
        end
        WAIT_WACK: begin
          if (tx_write_ack) begin
            r_state <= WAIT_RESP;
            r_timer <= TW'(TIMEOUT);
          end else if (tx_no_ack) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
            r_err   <= 2'd1;
          end
        end
        WAIT_RESP: begin
          if (w_fire) begin
            r_rx_read <= 1'b1;
            r_rx_seen <= 1'b1;
          end
          if (w_fire && rx_scan_code == 8'hFA) begin
            r_retry <= '0;
            if (r_cmd == CMD_RST) begin
              r_state <= WAIT_BAT;
              r_timer <= TW'(TIMEOUT);
            end else if (!r_idx) begin
              r_idx   <= 1'b1;
              r_state <= SEND;
            end else begin
              r_state <= FINISH;
              r_done  <= 1'b1;
              r_err   <= 2'd0;
            end
          end else if (w_fire && rx_scan_code == 8'hFE) begin
            if (r_retry < RW'(MAX_RETRY)) begin
              r_retry <= r_retry + 1'b1;
              r_state <= SEND;
            end else begin
              r_state <= FINISH;
              r_done  <= 1'b1;
              r_err   <= 2'd3;
            end
          end else if (r_timer == TW'(1)) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
            r_err   <= 2'd2;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        WAIT_BAT: begin
          if (w_fire) begin
            r_rx_read <= 1'b1;
            r_rx_seen <= 1'b1;
          end
          if (w_fire && rx_scan_code == 8'hAA) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
            r_err   <= 2'd0;
          end else if (w_fire && rx_scan_code == 8'hFC) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
            r_err   <= 2'd3;
          end else if (r_timer == TW'(1)) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
            r_err   <= 2'd2;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        FINISH: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (r_state != IDLE) begin
        if (reset_req) r_pend_rst <= 1'b1;
        if (led_req) r_pend_led <= 1'b1;
`ifdef PS2_CMD_TYPEMATIC_EN
        if (typematic_req) r_pend_typ <= 1'b1;
`endif
      end
    end
  end

endmodule
